// File: rtl/arbiter_rr_n.sv
// arbiter_rr_n
//   N_CH-channel round-robin arbiter feeding a single registered output
//   word, with valid/ready handshaking on every port.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_valid    [N_CH]          per-channel request
//   i_data     [N_CH*DATA_W]   per-channel payload, channel k at [k*DATA_W +: DATA_W]
//   o_ready    [N_CH]          per-channel accept (combinational, one-hot or zero)
//   o_valid    output word valid (registered)
//   o_data     [DATA_W] output payload (registered)
//   o_id       [ID_W]   channel that supplied o_data (registered)
//   i_ready    downstream accept

// Per-channel accept: only the winning channel sees o_ready.
module arbiter_rr_n_lane #(
  parameter int IDX  = 0,
  parameter int ID_W = 2
) (
  input  logic            grant_en,
  input  logic [ID_W-1:0] win_idx,
  input  logic            valid,
  output logic            ready
);
  assign ready = grant_en && valid && (win_idx == ID_W'(IDX));
endmodule

module arbiter_rr_n #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int ID_W   = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [N_CH-1:0]          i_valid,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic [N_CH-1:0]          o_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [ID_W-1:0]          o_id,
  input  logic                     i_ready
);

  logic [N_CH-1:0][DATA_W-1:0] data_arr;
  logic [ID_W-1:0]             r_last;
  logic [ID_W-1:0]             win_idx;
  logic [ID_W-1:0]             cand;
  logic                        win_found;
  logic                        load;
  logic                        grant_en;
  logic                        xfer_in;

  assign data_arr = i_data;

  // Output register can accept a word when empty or draining this cycle.
  assign load = ~o_valid | i_ready;

  // Rotating search: start just after the last winner, wrap through r_last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = ID_W'((int'(r_last) + off) % N_CH);
      if (!win_found && i_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Gated with reset so no source sees an accept while the block is held.
  assign grant_en = load && win_found && i_reset_n;
  assign xfer_in  = grant_en;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    arbiter_rr_n_lane #(.IDX(k), .ID_W(ID_W)) u_lane (
      .grant_en (grant_en),
      .win_idx  (win_idx),
      .valid    (i_valid[k]),
      .ready    (o_ready[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_id    <= '0;
      r_last  <= ID_W'(N_CH - 1);   // channel 0 wins first
    end else if (xfer_in) begin
      o_valid <= 1'b1;
      o_data  <= data_arr[win_idx];
      o_id    <= win_idx;
      r_last  <= win_idx;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;              // drained, payload kept
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n.sv
module tb_arbiter_rr_n;
  localparam int N = 4;
  localparam int W = 16;

  logic              i_clk;
  logic              i_reset_n;
  logic [N-1:0]      i_valid;
  logic [N-1:0][W-1:0] dat;
  logic [N-1:0]      o_ready;
  logic              o_valid;
  logic [W-1:0]      o_data;
  logic [1:0]        o_id;
  logic              i_ready;

  int n_chk  = 0;
  int n_fail = 0;

  arbiter_rr_n #(.N_CH(N), .DATA_W(W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .i_data    (dat),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_id      (o_id),
    .i_ready   (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_id;
  int          m_last;

  function automatic int m_winner();
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_last + off) % N;
      if (i_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w;
    if (!i_reset_n) return '0;
    if (m_valid && !i_ready) return '0;
    w = m_winner();
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  always @(negedge i_reset_n) begin
    m_valid = 0; m_data = '0; m_id = 0; m_last = N - 1;
  end

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      logic [N-1:0] r;
      r = m_ready();
      if (r != '0) begin
        int w;
        w = m_winner();
        m_valid = 1; m_data = dat[w]; m_id = w; m_last = w;
      end else if (m_valid && i_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare process: mid low phase, after stimulus has settled.
  always @(negedge i_clk) begin
    #2;
    chk("m_o_ready", 32'(o_ready), 32'(m_ready()));
    chk("m_o_valid", 32'(o_valid), 32'(m_valid));
    chk("m_o_data",  32'(o_data),  32'(m_data));
    chk("m_o_id",    32'(o_id),    32'(m_id));
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #3 i_reset_n = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_valid = '0; i_ready = 1'b0; dat = '0;

    // Reset with inputs toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_valid = N'($urandom); i_ready = 1'($urandom); dat = {$urandom, $urandom};
      #3;
      chk("rst_o_valid", 32'(o_valid), 0);
      chk("rst_o_data",  32'(o_data),  0);
      chk("rst_o_id",    32'(o_id),    0);
      chk("rst_o_ready", 32'(o_ready), 0);
    end
    @(negedge i_clk);
    i_valid = 4'b0001; dat = '0; dat[0] = 16'hA5A5; i_ready = 1'b1;
    #3 i_reset_n = 1'b1;
    #1 chk("first_ready", 32'(o_ready), 32'h1);
    after_edge();
    chk("first_valid", 32'(o_valid), 1);
    chk("first_data",  32'(o_data),  32'hA5A5);
    chk("first_id",    32'(o_id),    0);

    // Round-robin rotation
    do_reset();
    i_valid = 4'b1111; i_ready = 1'b1;
    for (int k = 0; k < N; k++) dat[k] = 16'(16'h1000 + k);
    for (int i = 0; i < 8; i++) begin
      after_edge();
      chk("rot_id",    32'(o_id),    32'(i % 4));
      chk("rot_data",  32'(o_data),  32'(16'h1000 + (i % 4)));
      chk("rot_valid", 32'(o_valid), 1);
    end

    // Sparse requests and wrap (last grant was 3)
    @(negedge i_clk);
    i_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      after_edge();
      chk("sparse_id", 32'(o_id), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    @(negedge i_clk);
    i_valid = 4'b0001;
    after_edge();
    chk("wrap_id", 32'(o_id), 0);

    // Backpressure
    @(negedge i_clk);
    i_valid = 4'b0100; dat[2] = 16'hBEEF;
    after_edge();
    chk("bp_setup_id", 32'(o_id), 2);
    @(negedge i_clk);
    i_valid = 4'b1111; i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(o_ready), 0);
      after_edge();
      chk("bp_valid", 32'(o_valid), 1);
      chk("bp_data",  32'(o_data),  32'hBEEF);
      chk("bp_id",    32'(o_id),    2);
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(o_ready), 32'b1000);
    after_edge();
    chk("bp_release_id",    32'(o_id),    3);
    chk("bp_release_valid", 32'(o_valid), 1);

    // Idle drain
    @(negedge i_clk);
    i_valid = 4'b0010; dat[1] = 16'h5A5A;
    after_edge();
    chk("drain_id", 32'(o_id), 1);
    @(negedge i_clk);
    i_valid = 4'b0000;
    after_edge();
    chk("drain_valid", 32'(o_valid), 0);
    chk("drain_data",  32'(o_data),  32'h5A5A);
    @(negedge i_clk);
    i_valid = 4'b0001;
    #1 chk("drain_next_ready", 32'(o_ready), 32'b0001);
    after_edge();
    chk("drain_next_id", 32'(o_id), 0);

    // Mid-stream reset
    @(negedge i_clk);
    i_valid = 4'b1111; i_ready = 1'b1;
    after_edge();
    after_edge();
    chk("mid_pre_valid", 32'(o_valid), 1);
    @(negedge i_clk);
    #3 i_reset_n = 1'b0;
    #1;
    chk("mid_valid", 32'(o_valid), 0);
    chk("mid_id",    32'(o_id),    0);
    chk("mid_ready", 32'(o_ready), 0);
    @(negedge i_clk);
    #3 i_reset_n = 1'b1;
    after_edge();
    chk("mid_after_id", 32'(o_id), 0);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      i_valid = N'($urandom_range(0, 15));
      i_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) dat[k] = W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #3 i_reset_n = 1'b0;
        #1 i_reset_n = 1'b1;
      end
    end

    @(negedge i_clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arbiter_rr_n.md
# arbiter_rr_n

Parametrised N-channel round-robin arbiter with a registered output stage and valid/ready handshaking on every port. Up to N_CH producers present DATA_W-bit words. One word per cycle is granted fairly and written to a single registered output, together with the index of the winning channel. It sits where the two-input arbiter is used today, in front of any single-consumer sink that can apply backpressure.

## Interface
- N_CH, default 4: number of input channels; legal range 2..16.
- DATA_W, default 16: payload width in bits; must be at least 1.
- ID_W, default $clog2(N_CH): width of the channel-index output; derived, not overridden.

Ports:
- i_clk  input  1  clock. All state updates on the rising edge.
- i_reset_n  input  1  reset, asynchronous, active-low. Clock is i_clk.
- i_valid  input  N_CH  per-channel request; bit k belongs to channel k.
- i_data  input  N_CH*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
- o_ready  output  N_CH  per-channel accept; combinational.
- o_valid  output  1  output word valid; registered.
- o_data  output  DATA_W  output payload; registered.
- o_id  output  ID_W  index of the channel that supplied o_data; registered.
- i_ready  input  1  downstream accept.

## Operation
- Input transfer on channel k: i_valid[k] && o_ready[k] at a clock edge. Output transfer: o_valid && i_ready at a clock edge.
- Input load enable: `load = ~o_valid | i_ready`. The output register can take a new word when it is empty or is being drained in the same cycle.
- Priority pointer r_last (ID_W bits) holds the most recently granted channel.
  - Search order starts at channel r_last+1 and wraps modulo N_CH through to r_last.
  - The winner is the first channel in that order with i_valid set. At most one winner exists.
- o_ready[k] = load && (k == winner) && i_valid[k]. At most one o_ready bit is high in any cycle. All o_ready bits are 0 when load is 0 or when no channel is valid.
- On an input transfer from channel k:
  - o_data <= i_data[k], o_id <= k, o_valid <= 1, r_last <= k.
- Output handling when there is no input transfer:
  - If an output transfer occurs, o_valid <= 0. o_data and o_id keep their values.
  - Otherwise all registers hold.
- r_last changes only on an input transfer. Cycles with backpressure or no requests do not advance the pointer.
- Stability: while o_valid && !i_ready, o_valid, o_data and o_id hold constant.
- A source's i_valid may drop without a transfer; the arbiter tolerates this. Fairness is defined only for sources that hold i_valid until accepted.
- Fairness: a channel holding i_valid continuously is granted within N_CH input transfers.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): o_valid=0, o_data=0, o_id=0, r_last=N_CH-1, so channel 0 has highest priority at the first grant.
- Reset asserted mid-operation: the pending output word is discarded and all registers return to their reset values immediately. o_ready goes to 0 while reset is asserted.
- Latency: one cycle. A word accepted at edge t appears on o_data/o_valid immediately after edge t.
- Throughput: one word per cycle while i_ready=1 and at least one i_valid is set. There are no bubbles when switching channels.
- Simultaneous output drain and input load in the same cycle: the register is overwritten and o_valid stays 1.
- Backpressure: when o_valid=1 and i_ready=0, all o_ready bits are 0 in that cycle.
- Single requester: the same channel is granted every cycle. r_last stays at that index.
- Wrap-around: r_last=N_CH-1 makes channel 0 the first candidate.

## Test plan
- Reset check: apply reset with all inputs toggling. Required response: o_valid=0, o_data=0, o_id=0, o_ready=0. After release, with i_valid=4'b0001, i_data[0]=16'hA5A5, i_ready=1: o_ready[0]=1 in that cycle, and o_valid=1, o_data=16'hA5A5, o_id=0 one cycle later.
- Round-robin rotation (N_CH=4): hold i_valid=4'b1111 with i_data[k]=16'h1000+k and i_ready=1 for 8 cycles. Required o_id sequence: 0,1,2,3,0,1,2,3. Required o_data sequence: 16'h1000..16'h1003 repeated. o_valid=1 continuously.
- Sparse requests and wrap: i_valid=4'b1010 constantly. Required o_id sequence: 1,3,1,3. Then switch to i_valid=4'b0001 after a grant to channel 3. Required next o_id=0.
- Backpressure: with output valid (o_id=2, o_data=16'hBEEF), hold i_ready=0 for 5 cycles with i_valid=4'b1111. Required: o_data/o_id/o_valid stable, all o_ready=0, r_last unchanged. Then raise i_ready. Required: the next grant is channel 3 and is loaded in the same cycle as the drain, with no bubble.
- Idle drain: a single transfer from channel 1, then i_valid=0 and i_ready=1. Required: o_valid falls to 0 one cycle after the data is consumed, o_data holds its last value, and the next request from channel 0 is granted.
- Mid-stream reset: assert i_reset_n=0 asynchronously while o_valid=1 and all channels are requesting. Required: o_valid=0 and o_id=0 at once, with no clock edge needed. After release, channel 0 wins first.
